// File: rtl/quadrature_paddle.sv
// Rotary-encoder front end for one pong paddle: synchronise, debounce, decode quadrature,
// accumulate sub-steps into detents and track a saturating paddle position.
module quadrature_paddle #(
  parameter int unsigned DEBOUNCE_CYCLES  = 1024,
  parameter int unsigned DB_WIDTH         = 11,
  parameter int unsigned STEPS_PER_DETENT = 4,
  parameter int unsigned POS_WIDTH        = 5,
  parameter int unsigned POS_MAX          = 31,
  parameter int unsigned POS_INIT         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a,
  input  logic                 b,
  output logic [POS_WIDTH-1:0] pos,
  output logic                 up,
  output logic                 down,
  output logic                 err
);

  localparam logic [DB_WIDTH-1:0]  DbLast  = DB_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic signed [3:0]    SubLast = 4'(STEPS_PER_DETENT - 1);
  localparam logic [POS_WIDTH-1:0] PosMax  = POS_WIDTH'(POS_MAX);
  localparam logic [POS_WIDTH-1:0] PosInit = POS_WIDTH'(POS_INIT);

  // Channel bit 1 is a, bit 0 is b throughout.
  logic [1:0]          sync1_q, sync2_q, deb_q, prev_q;
  logic [DB_WIDTH-1:0] cnt_q [2];

  logic signed [3:0]    sub_q, sub_d;
  logic [POS_WIDTH-1:0] pos_q, pos_d;
  logic                 up_q, up_d, down_q, down_d, err_q, err_d;

  // Gray code to ring index: 00->0, 01->1, 11->2, 10->3 so CW is +1 mod 4.
  function automatic logic [1:0] ring_idx(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= {a, b};
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        deb_q[i] <= 1'b1;
        cnt_q[i] <= '0;
      end else if (sync2_q[i] == deb_q[i]) begin
        cnt_q[i] <= '0;
      end else if (cnt_q[i] == DbLast) begin
        deb_q[i] <= sync2_q[i];
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    logic [1:0] diff;
    logic       step_up, step_dn;
    diff    = ring_idx(deb_q) - ring_idx(prev_q);
    sub_d   = sub_q;
    step_up = 1'b0;
    step_dn = 1'b0;
    err_d   = (diff == 2'd2);
    if (diff == 2'd1) begin
      if (sub_q == SubLast) begin
        sub_d   = '0;
        step_up = 1'b1;
      end else begin
        sub_d = sub_q + 4'sd1;
      end
    end else if (diff == 2'd3) begin
      if (sub_q == -SubLast) begin
        sub_d   = '0;
        step_dn = 1'b1;
      end else begin
        sub_d = sub_q - 4'sd1;
      end
    end
    // A step at a rail still consumes the detent but produces no pulse.
    up_d   = step_up && (pos_q != PosMax);
    down_d = step_dn && (pos_q != '0);
    pos_d  = pos_q;
    if (up_d) begin
      pos_d = pos_q + 1'b1;
    end else if (down_d) begin
      pos_d = pos_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 2'b11;
      sub_q  <= '0;
      pos_q  <= PosInit;
      up_q   <= 1'b0;
      down_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= deb_q;
      sub_q  <= sub_d;
      pos_q  <= pos_d;
      up_q   <= up_d;
      down_q <= down_d;
      err_q  <= err_d;
    end
  end

  assign pos  = pos_q;
  assign up   = up_q;
  assign down = down_q;
  assign err  = err_q;

endmodule
